// File: rtl/rng_sample_fifo.sv
// Circular sample FIFO fed by the LFSR random-integer generator, with optional decimation.
// The host configures it, pops samples and reads status through the shared 16-bit MMIO port.
module rng_sample_fifo #(
   parameter int n     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [n-1:0]  in_data,
   input  logic          W,
   input  logic          R,
   input  logic [15:0]   A,
   input  logic [n-1:0]  D,
   output logic [n-1:0]  RD,
   output logic          rd_valid,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [15:0] CFG_ADDR  = 16'h0016;
   localparam logic [15:0] DATA_ADDR = 16'h0018;
   localparam logic [15:0] STAT_ADDR = 16'h001A;

   logic [n-1:0]  mem_q [DEPTH];
   logic          en_q, en_d;
   logic [3:0]    div_q, div_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [n-1:0]  rd_q, rd_d;
   logic          rd_valid_q, rd_valid_d;
   logic          of_q, of_d;
   logic          uf_q, uf_d;

   logic          cfg_wr, clr, pop_req, stat_req, push_req;
   logic          pop_ok, push_ok, push_drop;
   logic [3:0]    cnt_clip, cnt_vis;
   logic [n+8:0]  stat_wide;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = of_q;
   assign RD       = rd_q;
   assign rd_valid = rd_valid_q;

   assign cfg_wr   = W && (A == CFG_ADDR);
   assign clr      = cfg_wr && D[1];
   assign pop_req  = R && (A == DATA_ADDR);
   assign stat_req = R && (A == STAT_ADDR);

   // Decimation uses the EN/DIV already in effect; a CFG write only lands next cycle.
   assign push_req  = in_valid && en_q && (dcnt_q == div_q);
   assign pop_ok    = pop_req && !empty && !clr;
   assign push_ok   = push_req && !clr && (!full || pop_ok);
   assign push_drop = push_req && !clr && full && !pop_ok;

   // The count field only exists when the data word is wide enough to carry bits [8:5].
   assign cnt_clip  = (int'(count_q) > 15) ? 4'hF : 4'(count_q);
   assign cnt_vis   = (n >= 9) ? cnt_clip : 4'd0;
   assign stat_wide = {{n{1'b0}}, cnt_vis, en_q, uf_q, of_q, full, empty};

   always_comb begin
      // NOTE: every next-state signal is given a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      en_d       = en_q;
      div_d      = div_q;
      dcnt_d     = dcnt_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      of_d       = of_q;
      uf_d       = uf_q;
      rd_d       = rd_q;
      rd_valid_d = pop_req || stat_req;

      if (pop_req) begin
         rd_d = pop_ok ? mem_q[rptr_q] : '0;
      end else if (stat_req) begin
         rd_d = stat_wide[n-1:0];
      end

      if (cfg_wr) begin
         en_d   = D[0];
         div_d  = D[5:2];
         dcnt_d = '0;
      end else if (in_valid && en_q) begin
         dcnt_d = push_req ? 4'd0 : dcnt_q + 4'd1;
      end

      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         of_d    = 1'b0;
         uf_d    = 1'b0;
      end else begin
         if (pop_ok)              rptr_d = rptr_q + AW'(1);
         if (push_ok)             wptr_d = wptr_q + AW'(1);
         if (pop_req && empty)    uf_d   = 1'b1;
         if (push_drop)           of_d   = 1'b1;
         if (push_ok && !pop_ok)  count_d = count_q + (AW+1)'(1);
         if (pop_ok && !push_ok)  count_d = count_q - (AW+1)'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         en_q       <= 1'b0;
         div_q      <= '0;
         dcnt_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         of_q       <= 1'b0;
         uf_q       <= 1'b0;
      end else begin
         en_q       <= en_d;
         div_q      <= div_d;
         dcnt_q     <= dcnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
         of_q       <= of_d;
         uf_q       <= uf_d;
      end
   end

   // NOTE: the storage array has no reset; stale entries are never visible because a
   // pop only reads when count is non-zero, and leaving it unreset keeps it a plain RAM.
   always_ff @(posedge clock) begin
      if (push_ok && !reset) mem_q[wptr_q] <= in_data;
   end

endmodule

// File: tb/tb_rng_sample_fifo.sv
// Bench for rng_sample_fifo: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the FIFO's MMIO behaviour.
module tb_rng_sample_fifo;

   localparam int N     = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam logic [15:0] CFG  = 16'h0016;
   localparam logic [15:0] DATA = 16'h0018;
   localparam logic [15:0] STAT = 16'h001A;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          W, R;
   logic [15:0]   A;
   logic [N-1:0]  D;
   logic [N-1:0]  RD;
   logic          rd_valid, full, empty, overflow;
   logic [AW:0]   count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] q[$];
   bit         m_en, m_of, m_uf, m_rdv;
   bit [3:0]   m_div, m_dcnt;
   logic [7:0] m_rd;

   rng_sample_fifo #(.n(N), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .W(W), .R(R), .A(A), .D(D), .RD(RD), .rd_valid(rd_valid),
      .full(full), .empty(empty), .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   // Drive one cycle of inputs, advance the model, and return #1 after the edge.
   task automatic step(input bit rst, input bit iv, input logic [7:0] idat,
                       input bit w, input bit r, input logic [15:0] a, input logic [7:0] d);
      bit cfg, clr, pop, stat, push;
      logic [7:0] st;
      reset = rst; in_valid = iv; in_data = idat; W = w; R = r; A = a; D = d;
      if (rst) begin
         q.delete();
         m_en = 0; m_div = 0; m_dcnt = 0; m_of = 0; m_uf = 0; m_rd = 8'h00; m_rdv = 0;
      end else begin
         cfg  = w && (a == CFG);
         clr  = cfg && d[1];
         pop  = r && (a == DATA);
         stat = r && (a == STAT);
         push = iv && m_en && (m_dcnt == m_div);
         st   = {3'b000, m_en, m_uf, m_of, q.size() == DEPTH, q.size() == 0};
         m_rdv = pop || stat;
         if (pop)       m_rd = (clr || q.size() == 0) ? 8'h00 : q[0];
         else if (stat) m_rd = st;
         if (clr) begin
            q.delete(); m_of = 0; m_uf = 0;
         end else begin
            if (pop) begin
               if (q.size() > 0) void'(q.pop_front());
               else m_uf = 1;
            end
            if (push) begin
               if (q.size() < DEPTH) q.push_back(idat);
               else m_of = 1;
            end
         end
         if (cfg) begin
            m_en = d[0]; m_div = d[5:2]; m_dcnt = 0;
         end else if (iv && m_en) begin
            m_dcnt = push ? 4'd0 : m_dcnt + 4'd1;
         end
      end
      @(posedge clock); #1;
      reset = 0; in_valid = 0; W = 0; R = 0;
   endtask

   task automatic idle();                   step(0, 0, 8'h00, 0, 0, 16'h0000, 8'h00); endtask
   task automatic cfg_wr(input logic [7:0] d); step(0, 0, 8'h00, 1, 0, CFG, d);      endtask
   task automatic push(input logic [7:0] x);   step(0, 1, x, 0, 0, 16'h0000, 8'h00); endtask
   task automatic rd_data();                step(0, 0, 8'h00, 0, 1, DATA, 8'h00);     endtask
   task automatic rd_stat();                step(0, 0, 8'h00, 0, 1, STAT, 8'h00);     endtask

   task automatic test_reset();
      // Reset must override a concurrent CFG write, push and read.
      step(1, 1, 8'hFF, 1, 1, CFG, 8'hFF);
      checks++; if (count !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0 || RD !== 8'h00) begin
         errors++; $display("FAIL reset_flags: full=%b ovf=%b rdv=%b RD=%h expected 0/0/0/00", full, overflow, rd_valid, RD); end
      rd_stat();
      checks++; if (rd_valid !== 1'b1 || RD !== 8'h01) begin
         errors++; $display("FAIL reset_stat: rdv=%b RD=%h expected 1/01", rd_valid, RD); end
      step(0, 0, 8'h00, 0, 1, 16'h0020, 8'h00);
      checks++; if (rd_valid !== 1'b0 || RD !== 8'h01) begin
         errors++; $display("FAIL unmapped_read: rdv=%b RD=%h expected 0/01", rd_valid, RD); end
      rd_data();
      checks++; if (rd_valid !== 1'b1 || RD !== 8'h00) begin
         errors++; $display("FAIL underflow_pop: rdv=%b RD=%h expected 1/00", rd_valid, RD); end
      rd_stat();
      checks++; if (RD !== 8'h09) begin errors++; $display("FAIL underflow_stat: got %h expected 09", RD); end
   endtask

   task automatic test_basic();
      logic [7:0] exp_v [3] = '{8'hA1, 8'hA2, 8'hA3};
      cfg_wr(8'h01);
      for (int i = 0; i < 3; i++) push(exp_v[i]);
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
      for (int i = 0; i < 3; i++) begin
         rd_data();
         checks++; if (rd_valid !== 1'b1 || RD !== exp_v[i]) begin
            errors++; $display("FAIL basic_pop%0d: rdv=%b RD=%h expected 1/%h", i, rd_valid, RD, exp_v[i]); end
      end
      idle();
      checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin
         errors++; $display("FAIL basic_drained: rdv=%b empty=%b expected 0/1", rd_valid, empty); end
   endtask

   task automatic test_decimation();
      logic [7:0] exp_v [3] = '{8'h03, 8'h06, 8'h09};
      cfg_wr(8'h09);
      for (int i = 1; i <= 9; i++) push(8'(i));
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL decim_count: got %0d expected 3", count); end
      for (int i = 0; i < 3; i++) begin
         rd_data();
         checks++; if (RD !== exp_v[i]) begin
            errors++; $display("FAIL decim_pop%0d: got %h expected %h", i, RD, exp_v[i]); end
      end
   endtask

   task automatic test_overflow();
      cfg_wr(8'h01);
      for (int i = 1; i <= 17; i++) push(8'(i));
      checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_state: count=%0d full=%b ovf=%b expected 16/1/1", count, full, overflow); end
      for (int i = 1; i <= 16; i++) begin
         rd_data();
         checks++; if (RD !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, RD, 8'(i)); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: empty=%b expected 1", empty); end
   endtask

   task automatic test_full_pushpop();
      cfg_wr(8'h03);
      for (int i = 0; i < 16; i++) push(8'(8'h21 + i));
      step(0, 1, 8'h55, 0, 1, DATA, 8'h00);
      checks++; if (RD !== 8'h21 || count !== 5'd16 || overflow !== 1'b0) begin
         errors++; $display("FAIL full_pushpop: RD=%h count=%0d ovf=%b expected 21/16/0", RD, count, overflow); end
      for (int i = 0; i < 16; i++) begin
         rd_data();
         checks++; if (RD !== ((i == 15) ? 8'h55 : 8'(8'h22 + i))) begin
            errors++; $display("FAIL full_drain%0d: got %h expected %h", i, RD, (i == 15) ? 8'h55 : 8'(8'h22 + i)); end
      end
   endtask

   task automatic test_clr();
      for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
      for (int i = 0; i < 11; i++) rd_data();
      checks++; if (count !== 5'd5 || overflow !== 1'b1) begin
         errors++; $display("FAIL clr_setup: count=%0d ovf=%b expected 5/1", count, overflow); end
      step(0, 1, 8'hEE, 1, 0, CFG, 8'h03);
      checks++; if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
         errors++; $display("FAIL clr_state: count=%0d empty=%b ovf=%b expected 0/1/0", count, empty, overflow); end
      rd_stat();
      checks++; if (RD !== 8'h11) begin errors++; $display("FAIL clr_stat: got %h expected 11", RD); end
   endtask

   task automatic test_random();
      bit iv, w, r, rst;
      logic [15:0] a;
      logic [7:0] d;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         iv  = ($urandom_range(0, 2) != 0);
         w   = ($urandom_range(0, 9) == 0);
         r   = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0: a = CFG;
            1: a = DATA;
            2: a = STAT;
            default: a = 16'($urandom_range(0, 65535));
         endcase
         d = {2'b00, 4'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) != 0)};
         step(rst, iv, 8'($urandom), w, r, a, d);
         checks++; if (rd_valid !== m_rdv || RD !== m_rd) begin
            errors++; $display("FAIL rand_read@%0d: rdv=%b RD=%h expected %b/%h", i, rd_valid, RD, m_rdv, m_rd); end
         checks++; if (count !== 5'(q.size()) || full !== (q.size() == DEPTH) ||
                       empty !== (q.size() == 0) || overflow !== m_of) begin
            errors++; $display("FAIL rand_state@%0d: count=%0d full=%b empty=%b ovf=%b expected %0d/%b/%b/%b",
                               i, count, full, empty, overflow, q.size(), q.size() == DEPTH, q.size() == 0, m_of); end
      end
   endtask

   initial begin
      reset = 1; in_valid = 0; in_data = '0; W = 0; R = 0; A = '0; D = '0;
      step(1, 0, 8'h00, 0, 0, 16'h0000, 8'h00);
      test_reset();
      test_basic();
      test_decimation();
      test_overflow();
      test_full_pushpop();
      test_clr();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rng_sample_fifo.md
Name: rng_sample_fifo

Overview:
Downstream consumer of the LFSR random-integer generator. It captures LFSR output words, with optional decimation, into a circular FIFO. The host drains the FIFO and reads status through the same 16-bit MMIO address space and write strobe the LFSR uses. It lets software collect bursts of continuous-mode random numbers without keeping pace with every clock edge.

Parameters:
n, 8, data width; must equal the LFSR width; minimum 8.
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clock  input  1  clock, rising-edge active
reset  input  1  reset, synchronous, active-high
in_valid  input  1  in_data holds a new LFSR word this cycle
in_data  input  n  LFSR output word
W  input  1  MMIO write strobe
R  input  1  MMIO read strobe
A  input  16  MMIO address
D  input  n  MMIO write data
RD  output  n  MMIO read data, registered
rd_valid  output  1  RD valid, one-cycle pulse
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Address map:
  - CFG_REG 0x0016: write-only.
  - DATA_REG 0x0018: read pops one entry.
  - STAT_REG 0x001A: read-only.
  - Reads of any other address give no rd_valid, and RD holds its value.
- CFG write, W && A==0x0016:
  - D[0] sets EN, the capture enable.
  - D[1] is CLR, self-clearing and not stored.
  - D[5:2] sets DIV, the decimation divisor.
  - EN and DIV take effect on the next cycle.
  - Any CFG write resets the decimation counter to 0.
- Decimation:
  - dcnt is a 4-bit counter that advances on each in_valid while EN=1.
  - When in_valid && EN && dcnt==DIV, a push is requested and dcnt returns to 0. Otherwise dcnt increments.
  - DIV=0 means every valid word is captured. DIV=k means one word in k+1 is captured.
  - in_valid while EN=0 is ignored and dcnt holds.
- Push:
  - If count<DEPTH, or a pop happens in the same cycle, write in_data at wptr and increment wptr modulo DEPTH.
  - Otherwise drop the word and set overflow. count is unchanged.
- Pop, R && A==0x0018:
  - If not empty: RD <= mem[rptr] on the next edge, rptr increments modulo DEPTH, and rd_valid=1 the following cycle. Read latency is 1 cycle.
  - If empty: RD <= 0, rd_valid pulses, and sticky underflow is set. Pointers are unchanged.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - When full, the push is accepted and there is no overflow.
  - When empty, the pop underflows and the push completes.
- Status read, R && A==0x001A:
  - RD <= {zeros, count[3:0] clipped, EN, underflow, overflow, full, empty}, at bits [8:5] unused when n=8.
  - For n=8 the layout is: bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bit4 EN, bits7:5 = 0.
  - rd_valid pulses after 1 cycle.
- CLR:
  - Pointers, count, overflow, underflow and dcnt go to 0 at the end of the write cycle.
  - A push or pop requested in the same cycle as CLR is discarded, and that pop's rd_valid still pulses with RD=0.
  - Stored memory contents are not cleared.
- W and R in the same cycle are processed independently.
- Reset: EN=0, DIV=0, dcnt=0, pointers=0, count=0, RD=0, rd_valid=0, overflow=0, underflow=0. Consequently empty=1 and full=0. Memory contents are undefined and must not be observable.
- Reset mid-operation: the synchronous reset overrides all pending push, pop and CFG writes in that cycle.
- full, empty and count are combinational from the registered count. Mem is written only on an accepted push.

Test Plan:
- Reset, then read STAT -> rd_valid 1 cycle later with RD=0x01 (empty). Read DATA -> RD=0x00 and STAT then reads 0x09 (underflow set).
- CFG D=0x01, drive in_valid with in_data 0xA1,0xA2,0xA3 on consecutive cycles, then 3 DATA reads -> RD=0xA1,0xA2,0xA3 in order, each with 1-cycle latency, then empty=1.
- CFG D=0x09 (EN, DIV=2), drive 9 consecutive valid words 0x01..0x09 -> FIFO holds 0x03,0x06,0x09 and count=3.
- EN=1, DIV=0, push 17 words with DEPTH=16 -> full=1, overflow=1, count=16. Drained data is words 1..16, word 17 is lost, and wrap-around order is preserved.
- While full, assert in_valid and a DATA read in the same cycle -> count stays 16, no overflow, the popped word is the oldest and the new word lands at the tail.
- With count=5 and overflow=1, CFG write D=0x03 (EN plus CLR) with a concurrent in_valid -> next cycle count=0, empty=1, overflow=0, EN=1, and that word is not captured.
